// File: rtl/serializer_sched.sv
// Round-robin scheduler sharing one byte serializer between N_REQ requesters.
// Ports: clk, rst (sync, active-high)
//        req_valid/req_data in, req_ready out (one-hot accept, IDLE only)
//        ser_load/ser_data to the serializer, grant_id, busy, frame_done status
module serializer_sched #(
   parameter int N_REQ      = 4,
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 1,
   parameter int GAP_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       ser_load,
   output logic [DATA_W-1:0]          ser_data,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy,
   output logic                       frame_done
);

   localparam int IW        = $clog2(N_REQ);
   localparam int SHIFT_LEN = DATA_W * BIT_CYCLES;
   localparam int CW        = $clog2(SHIFT_LEN + 1);
   localparam int GW        = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   logic [GW-1:0]     gap_q;
   logic [IW-1:0]     last_q;
   logic              ser_load_q;
   logic [DATA_W-1:0] ser_data_q;
   logic [IW-1:0]     grant_q;
   logic              busy_q;
   logic              frame_done_q;

   logic [IW:0]       sum_c;
   logic [IW-1:0]     idx_c;
   logic [IW-1:0]     win_d;
   logic              found_d;

   // Search last+1, last+2, ... with wrap; the first valid index wins.
   always_comb begin
      win_d   = '0;
      found_d = 1'b0;
      sum_c   = '0;
      idx_c   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         sum_c = {1'b0, last_q} + (IW+1)'(k);
         if (sum_c >= (IW+1)'(N_REQ)) begin
            sum_c = sum_c - (IW+1)'(N_REQ);
         end
         idx_c = sum_c[IW-1:0];
         if (!found_d && req_valid[idx_c]) begin
            found_d = 1'b1;
            win_d   = idx_c;
         end
      end
   end

   // Reset wins over a grant, so ready is masked while rst is high.
   assign req_ready = (state_q == IDLE && found_d && !rst)
                    ? (N_REQ'(1) << win_d) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         gap_q        <= '0;
         last_q       <= IW'(N_REQ - 1);
         ser_load_q   <= 1'b0;
         ser_data_q   <= '0;
         grant_q      <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (found_d) begin
                  ser_data_q <= req_data[win_d*DATA_W +: DATA_W];
                  grant_q    <= win_d;
                  last_q     <= win_d;
                  ser_load_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= LOAD;
               end
            end
            LOAD: begin
               ser_load_q   <= 1'b0;
               cnt_q        <= CW'(SHIFT_LEN);
               frame_done_q <= (SHIFT_LEN == 1);
               state_q      <= SHIFT;
            end
            SHIFT: begin
               // cnt_q holds the SHIFT cycles left, including this one.
               if (cnt_q == CW'(1)) begin
                  frame_done_q <= 1'b0;
                  if (GAP_CYCLES > 0) begin
                     gap_q   <= GW'(GAP_CYCLES);
                     state_q <= GAP;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q        <= cnt_q - 1'b1;
                  frame_done_q <= (cnt_q == CW'(2));
               end
            end
            GAP: begin
               if (gap_q == GW'(1)) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ser_load   = ser_load_q;
   assign ser_data   = ser_data_q;
   assign grant_id   = grant_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serializer_sched.sv
// Scoreboard bench for serializer_sched: default instance plus a
// BIT_CYCLES=3 / GAP_CYCLES=0 instance.
module tb_serializer_sched;

   typedef struct {
      int cyc;
      int gid;
      int data;
   } ld_t;

   logic        clk;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   ld_t         ld_q[$];
   int          dn_q[$];
   ld_t         s_ld_q[$];
   int          s_dn_q[$];

   logic        m_rst;
   logic [3:0]  m_valid;
   logic [31:0] m_data;
   logic [3:0]  m_ready;
   logic        m_load;
   logic [7:0]  m_sdata;
   logic [1:0]  m_gid;
   logic        m_busy;
   logic        m_done;

   logic        s_rst;
   logic [3:0]  s_valid;
   logic [31:0] s_data;
   logic [3:0]  s_ready;
   logic        s_load;
   logic [7:0]  s_sdata;
   logic [1:0]  s_gid;
   logic        s_busy;
   logic        s_done;

   serializer_sched dut (
      .clk(clk), .rst(m_rst), .req_valid(m_valid), .req_data(m_data),
      .req_ready(m_ready), .ser_load(m_load), .ser_data(m_sdata),
      .grant_id(m_gid), .busy(m_busy), .frame_done(m_done)
   );

   serializer_sched #(
      .N_REQ(4), .DATA_W(8), .BIT_CYCLES(3), .GAP_CYCLES(0)
   ) sdut (
      .clk(clk), .rst(s_rst), .req_valid(s_valid), .req_data(s_data),
      .req_ready(s_ready), .ser_load(s_load), .ser_data(s_sdata),
      .grant_id(s_gid), .busy(s_busy), .frame_done(s_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ld(input int c, input int g, input int d);
      ld_t e;
      e.cyc = c; e.gid = g; e.data = d;
      ld_q.push_back(e);
   endtask

   // Main-instance monitor: loads and frame_done pulses against the queues.
   always @(negedge clk) begin
      ld_t e;
      if (m_load === 1'b1) begin
         if (ld_q.size() == 0) chk("unexpected_load", 1, 0);
         else begin
            e = ld_q.pop_front();
            chk("load_cycle", cyc, e.cyc);
            chk("load_gid", {30'd0, m_gid}, e.gid);
            chk("load_data", {24'd0, m_sdata}, e.data);
         end
      end
      if (m_done === 1'b1) begin
         if (dn_q.size() == 0) chk("unexpected_done", 1, 0);
         else chk("done_cycle", cyc, dn_q.pop_front());
      end
      if (m_busy === 1'b1) chk("ready_while_busy", {28'd0, m_ready}, 0);
   end

   always @(negedge clk) begin
      ld_t e;
      if (s_load === 1'b1) begin
         if (s_ld_q.size() == 0) chk("s_unexpected_load", 1, 0);
         else begin
            e = s_ld_q.pop_front();
            chk("s_load_cycle", cyc, e.cyc);
            chk("s_load_data", {24'd0, s_sdata}, e.data);
         end
      end
      if (s_done === 1'b1) begin
         if (s_dn_q.size() == 0) chk("s_unexpected_done", 1, 0);
         else chk("s_done_cycle", cyc, s_dn_q.pop_front());
      end
   end

   initial begin
      int t0;
      ld_t e;
      m_rst = 1'b1; m_valid = 4'b1111; m_data = 32'h0;
      s_rst = 1'b1; s_valid = 4'b0000; s_data = 32'h0;

      // Reset state, with valids held to show reset priority.
      step(); step();
      @(negedge clk);
      chk("rst_load", {31'd0, m_load}, 0);
      chk("rst_data", {24'd0, m_sdata}, 0);
      chk("rst_gid", {30'd0, m_gid}, 0);
      chk("rst_busy", {31'd0, m_busy}, 0);
      chk("rst_done", {31'd0, m_done}, 0);
      chk("rst_ready", {28'd0, m_ready}, 0);

      // Single request.
      step();
      m_rst = 1'b0; m_valid = 4'b0001; m_data[7:0] = 8'hA5;
      t0 = cyc;
      push_ld(t0 + 1, 0, 'hA5);
      dn_q.push_back(t0 + 9);
      @(negedge clk);
      chk("single_ready", {28'd0, m_ready}, 4'b0001);
      chk("single_busy0", {31'd0, m_busy}, 0);
      step();
      m_valid = 4'b0000;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         chk("single_busy", {31'd0, m_busy}, (c <= 10) ? 1 : 0);
         step();
      end

      // All contend after a fresh reset.
      m_rst = 1'b1;
      step();
      m_rst = 1'b0; m_valid = 4'b1111; m_data = 32'h44332211;
      t0 = cyc;
      for (int i = 0; i < 5; i++) begin
         push_ld(t0 + 1 + 11*i, i % 4, 'h11 * (i % 4 + 1));
         dn_q.push_back(t0 + 9 + 11*i);
      end
      @(negedge clk);
      chk("contend_ready", {28'd0, m_ready}, 4'b0001);
      repeat (45) step();
      m_valid = 4'b0000;
      repeat (10) step();

      // Fairness between 1 and 3, then 0 and 2 join during 3's shift.
      m_valid = 4'b1010; m_data = 32'h63336160;
      t0 = cyc;
      push_ld(t0 + 1, 1, 'h61);
      push_ld(t0 + 12, 3, 'h63);
      push_ld(t0 + 23, 1, 'h61);
      push_ld(t0 + 34, 3, 'h63);
      push_ld(t0 + 45, 0, 'h60);
      for (int i = 0; i < 5; i++) dn_q.push_back(t0 + 9 + 11*i);
      @(negedge clk);
      chk("rr_ready", {28'd0, m_ready}, 4'b0010);
      repeat (37) step();
      m_valid = 4'b1111;
      repeat (8) step();
      m_valid = 4'b0000;
      repeat (10) step();

      // Mid-frame stimulus changes are ignored.
      m_valid = 4'b0001; m_data[7:0] = 8'h3C;
      t0 = cyc;
      push_ld(t0 + 1, 0, 'h3C);
      dn_q.push_back(t0 + 9);
      repeat (3) step();
      m_data[7:0] = 8'hC3; m_valid = 4'b0000;
      @(negedge clk);
      chk("mid_hold", {24'd0, m_sdata}, 'h3C);
      repeat (2) step();
      m_valid = 4'b0001;
      for (int c = 5; c <= 10; c++) begin
         @(negedge clk);
         chk("mid_ready", {28'd0, m_ready}, 0);
         chk("mid_data", {24'd0, m_sdata}, 'h3C);
         step();
      end
      @(negedge clk);
      chk("mid_idle_data", {24'd0, m_sdata}, 'h3C);
      chk("mid_idle_ready", {28'd0, m_ready}, 4'b0001);
      push_ld(t0 + 12, 0, 'hC3);
      dn_q.push_back(t0 + 20);
      step();
      m_valid = 4'b0000;
      repeat (10) step();

      // Reset in the middle of a shift.
      m_valid = 4'b0010; m_data[15:8] = 8'h77;
      t0 = cyc;
      push_ld(t0 + 1, 1, 'h77);
      @(negedge clk);
      chk("mrst_ready", {28'd0, m_ready}, 4'b0010);
      repeat (5) step();
      m_rst = 1'b1; m_valid = 4'b0000;
      step();
      m_rst = 1'b0; m_valid = 4'b1001;
      m_data[7:0] = 8'h90; m_data[31:24] = 8'h93;
      @(negedge clk);
      chk("mrst_load", {31'd0, m_load}, 0);
      chk("mrst_busy", {31'd0, m_busy}, 0);
      chk("mrst_gid", {30'd0, m_gid}, 0);
      chk("mrst_data", {24'd0, m_sdata}, 0);
      chk("mrst_done", {31'd0, m_done}, 0);
      chk("mrst_ready", {28'd0, m_ready}, 4'b0001);
      push_ld(t0 + 7, 0, 'h90);
      dn_q.push_back(t0 + 15);
      step();
      m_valid = 4'b0000;
      repeat (10) step();

      // Sweep instance: 24-cycle shift, no gap, 26-cycle load period.
      s_rst = 1'b0; s_valid = 4'b0001; s_data[7:0] = 8'hE1;
      t0 = cyc;
      for (int i = 0; i < 3; i++) begin
         e.cyc = t0 + 1 + 26*i; e.gid = 0; e.data = 'hE1;
         s_ld_q.push_back(e);
         s_dn_q.push_back(t0 + 25 + 26*i);
      end
      for (int c = 1; c <= 80; c++) begin
         step();
         if (c == 53) s_valid = 4'b0000;
         @(negedge clk);
         if (c == 25) chk("s_busy_last_shift", {31'd0, s_busy}, 1);
         if (c == 26) chk("s_busy_idle", {31'd0, s_busy}, 0);
      end

      chk("ld_q_drained", ld_q.size(), 0);
      chk("dn_q_drained", dn_q.size(), 0);
      chk("s_ld_q_drained", s_ld_q.size(), 0);
      chk("s_dn_q_drained", s_dn_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serializer_sched.md
Name: serializer_sched

Overview:
- Shares one byte serializer between several requesters.
- Accepts bytes from up to N_REQ sources using a round-robin valid/ready handshake.
- Drives the serializer's load strobe and parallel data.
- Holds off the next load until the current word has fully shifted out, plus an optional inter-frame gap.
- Sits directly in front of the serializer (ports clk, load, in_value, o_bit). ser_load connects to load; ser_data connects to in_value.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, serializer word width.
- BIT_CYCLES, 1, clock cycles per serialized bit (>=1).
- GAP_CYCLES, 1, idle cycles inserted after each frame (0 allowed = no gap).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester "byte available".
- req_data  in  N_REQ*DATA_W  flattened; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot accept strobe; a transfer occurs when valid & ready.
- ser_load  out  1  one-cycle load strobe to the serializer.
- ser_data  out  DATA_W  registered word presented to the serializer.
- grant_id  out  clog2(N_REQ)  index of the requester owning the current frame.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse in the last SHIFT cycle.

Behaviour:
- Reset values:
  - state=IDLE; ser_load=0; ser_data=0; grant_id=0; busy=0; frame_done=0; req_ready=0.
  - RR pointer last=N_REQ-1, so requester 0 has top priority first.
- State machine: IDLE -> LOAD -> SHIFT -> GAP -> IDLE. GAP is skipped when GAP_CYCLES=0 (SHIFT -> IDLE).
- IDLE:
  - req_ready is combinational from the state and req_valid.
  - If any req_valid is high, the winner is the first valid index searching last+1, last+2, ... with modulo-N_REQ wrap.
  - req_ready[winner]=1 in that same cycle; all other ready bits stay 0.
  - On that edge: ser_data<=req_data[winner]; grant_id<=winner; last<=winner; go to LOAD.
  - With no valids, stay in IDLE and keep req_ready=0.
- LOAD: exactly one cycle, ser_load=1, ser_data stable. Next state is SHIFT.
- SHIFT:
  - Lasts DATA_W*BIT_CYCLES cycles, counted by a down-counter loaded on entry. The counter is sized clog2(DATA_W*BIT_CYCLES+1).
  - frame_done=1 in the final SHIFT cycle.
  - ser_data holds its value throughout.
- GAP: GAP_CYCLES cycles, then IDLE.
- Latency: valid accepted in cycle t gives ser_load high in cycle t+1.
- Frame period with defaults: 1+1+8+1 = 11 cycles.
- req_ready is never asserted outside IDLE. Changes on valid/data during LOAD, SHIFT or GAP are ignored.
- A requester may drop valid before it is granted; no transfer occurs and its RR position is unaffected.
- Simultaneous valids are served strictly round-robin. One requester with continuous valid gets back-to-back frames at the 11-cycle period.
- Reset mid-frame (any state): all outputs take reset values on the next edge. The frame is abandoned, not retried, and last returns to N_REQ-1.
- Reset has priority over a simultaneous grant in IDLE: no transfer occurs and req_ready stays 0 while rst=1.
- ser_load is never asserted for more than one consecutive cycle. Two loads are always separated by at least DATA_W*BIT_CYCLES+GAP_CYCLES+1 cycles.

Test Plan:
- Single request: after reset, req_valid=4'b0001, data0=8'hA5 at cycle 0.
  - req_ready=0001 at cycle 0.
  - ser_load=1 and ser_data=A5 at cycle 1.
  - busy is high for cycles 1-10; frame_done is high at cycle 9.
  - The attached serializer emits A5.
- All-contend: req_valid=4'b1111 held; data = 8'h11, 8'h22, 8'h33, 8'h44.
  - Grants in order 0,1,2,3,0, with loads at cycles 1, 12, 23, 34, 45.
  - grant_id and ser_data match each grant.
- RR fairness: requesters 1 and 3 held valid.
  - Grants alternate 1,3,1,3.
  - Raising valid for requester 2 during requester 3's SHIFT gives the next grant to 0 if valid, otherwise 1.
- Mid-frame stimulus: change data0 and drop/raise req_valid during SHIFT.
  - req_ready stays 0.
  - ser_data is unchanged until the next IDLE grant.
- Reset mid-shift: assert rst at cycle 5 of a frame.
  - Next edge: ser_load=0, busy=0, grant_id=0, ser_data=0.
  - After rst falls with req_valid=1000,0001 (i.e. 4'b1001), requester 0 is granted first.
- Parameter sweep (BIT_CYCLES=3, GAP_CYCLES=0):
  - SHIFT lasts 24 cycles.
  - Back-to-back loads are 26 cycles apart.
  - frame_done pulses once per frame.
